// File: rtl/product_accumulator.sv
// Sums COUNT unsigned 8-bit products, then holds the result until it is taken downstream.
// Define PRODUCT_ACC_SAT_EN for saturating accumulation with a sticky OVF; otherwise ACC wraps and OVF is 0.
module product_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [7:0]       i_p,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_ovf
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [3:0] LP_CNT_LAST = 4'(COUNT);

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt, w_acc_add;
    logic             r_ovf, w_ovf_nxt, w_ovf_add;
    logic [3:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             w_in_hs, w_out_hs;

`ifdef PRODUCT_ACC_SAT_EN
    logic [ACC_W:0] w_sum;
    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(i_p);

    // Carry out of the ACC_W-bit sum clamps to all-ones; OVF stays set once raised.
    always_comb begin
        w_acc_add = w_sum[ACC_W-1:0];
        w_ovf_add = r_ovf;
        if (w_sum[ACC_W]) begin
            w_acc_add = '1;
            w_ovf_add = 1'b1;
        end
    end
`else
    assign w_acc_add = r_acc + ACC_W'(i_p);
    assign w_ovf_add = 1'b0;
`endif

    // Handshake flags come straight from the state register, never from the peer's valid/ready.
    assign o_in_ready  = (r_state == ST_ACCUM);
    assign o_out_valid = (r_state == ST_HOLD);
    assign o_acc       = r_acc;
    assign o_ovf       = r_ovf;

    assign w_in_hs   = i_in_valid & o_in_ready;
    assign w_out_hs  = o_out_valid & i_out_ready;
    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        if (i_clr) begin
            w_state_nxt = ST_ACCUM;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_in_hs) begin
                        w_acc_nxt = w_acc_add;
                        w_ovf_nxt = w_ovf_add;
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == LP_CNT_LAST) w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_out_hs) begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: three instances (COUNT=4, 8, 1) sharing clock and reset.
module tb_product_accumulator;
    localparam int W = 10;
`ifdef PRODUCT_ACC_SAT_EN
    localparam int EXP_B_ACC = 1023;
    localparam int EXP_B_OVF = 1;
`else
    localparam int EXP_B_ACC = 776;
    localparam int EXP_B_OVF = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic a_clr = 0, a_iv = 0, a_or = 0, a_ir, a_ov, a_ovf;
    logic b_clr = 0, b_iv = 0, b_or = 0, b_ir, b_ov, b_ovf;
    logic c_clr = 0, c_iv = 0, c_or = 1, c_ir, c_ov, c_ovf;
    logic [7:0] a_p = 0, b_p = 0, c_p = 0;
    logic [W-1:0] a_acc, b_acc, c_acc;

    product_accumulator #(.COUNT(4), .ACC_W(W)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(a_clr), .i_in_valid(a_iv), .o_in_ready(a_ir),
        .i_p(a_p), .o_out_valid(a_ov), .i_out_ready(a_or), .o_acc(a_acc), .o_ovf(a_ovf));
    product_accumulator #(.COUNT(8), .ACC_W(W)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(b_clr), .i_in_valid(b_iv), .o_in_ready(b_ir),
        .i_p(b_p), .o_out_valid(b_ov), .i_out_ready(b_or), .o_acc(b_acc), .o_ovf(b_ovf));
    product_accumulator #(.COUNT(1), .ACC_W(W)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(c_clr), .i_in_valid(c_iv), .o_in_ready(c_ir),
        .i_p(c_p), .o_out_valid(c_ov), .i_out_ready(c_or), .o_acc(c_acc), .o_ovf(c_ovf));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: state is {ovf, acc}.
    function automatic logic [W:0] mdl_add(input logic [W:0] st, input logic [7:0] p);
        int s;
        s = int'(st[W-1:0]) + int'(p);
`ifdef PRODUCT_ACC_SAT_EN
        if (s > (1 << W) - 1) return {1'b1, {W{1'b1}}};
        return {st[W], W'(s)};
`else
        return {1'b0, W'(s)};
`endif
    endfunction

    logic [W:0] qa[$], qb[$], qc[$];
    logic [W:0] ma = '0, mb = '0;
    int cnt_a = 0;

    task automatic a_send(input logic [7:0] p);
        chk("a_in_ready", a_ir, 1);
        a_iv = 1; a_p = p;
        ma = mdl_add(ma, p);
        cnt_a++;
        if (cnt_a == 4) begin
            qa.push_back(ma);
            ma = '0;
            cnt_a = 0;
        end
        @(negedge clk);
        a_iv = 0;
    endtask

    task automatic a_take(input string tag);
        logic [W:0] e;
        for (int i = 0; i < 20 && !a_ov; i++) @(negedge clk);
        chk({tag, "_out_valid"}, a_ov, 1);
        chk({tag, "_q_size"}, qa.size(), 1);
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk({tag, "_acc"}, a_acc, e[W-1:0]);
            chk({tag, "_ovf"}, a_ovf, e[W]);
        end
        a_or = 1;
        @(negedge clk);
        a_or = 0;
        chk({tag, "_ready_after"}, a_ir, 1);
        chk({tag, "_acc_after"}, a_acc, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] e;
        int n_res;

        // Reset state before any clock edge
        #1;
        chk("rst_acc", a_acc, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_in_ready", a_ir, 1);
        chk("rst_ovf", a_ovf, 0);
        #1 rst_n = 1;
        @(negedge clk);

        // Asynchronous reset mid-accumulation at ACC=0x1A5
        a_send(8'd225);
        a_send(8'd196);
        chk("mid_acc_1a5", a_acc, 'h1A5);
        #2 rst_n = 0;
        #1;
        chk("async_rst_acc", a_acc, 0);
        chk("async_rst_out_valid", a_ov, 0);
        chk("async_rst_in_ready", a_ir, 1);
        ma = '0; cnt_a = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Basic accumulation with one-cycle latency to OUT_VALID
        a_send(8'd225);
        a_send(8'd21);
        a_send(8'd0);
        chk("basic_not_done", a_ov, 0);
        a_send(8'd18);
        chk("basic_latency", a_ov, 1);

        // Backpressure: HOLD ignores inputs
        a_iv = 1; a_p = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_acc", a_acc, 264);
            chk("bp_in_ready", a_ir, 0);
            chk("bp_out_valid", a_ov, 1);
            chk("bp_ovf", a_ovf, 0);
            @(negedge clk);
        end
        chk("bp_q_size", qa.size(), 1);
        e = qa.pop_front();
        chk("bp_model_acc", a_acc, e[W-1:0]);
        a_or = 1;
        @(negedge clk);
        a_or = 0; a_iv = 0;
        chk("bp_release_acc", a_acc, 0);
        chk("bp_release_ready", a_ir, 1);
        chk("bp_release_valid", a_ov, 0);
        @(negedge clk);
        chk("bp_none_consumed", a_acc, 0);

        // CLR wins over a simultaneous product
        a_send(8'd5);
        a_send(8'd6);
        a_clr = 1; a_iv = 1; a_p = 8'd100;
        @(negedge clk);
        a_clr = 0; a_iv = 0;
        chk("clr_acc", a_acc, 0);
        chk("clr_ready", a_ir, 1);
        ma = '0; cnt_a = 0;
        for (int i = 0; i < 4; i++) a_send(8'd1);
        chk("clr_then_four", a_acc, 4);
        a_take("clr");

        // A few random sets
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) a_send(8'($urandom_range(0, 255)));
            a_take("rand");
        end

        // Overflow with COUNT=8
        for (int i = 0; i < 8; i++) begin
            chk("b_in_ready", b_ir, 1);
            b_iv = 1; b_p = 8'd225;
            mb = mdl_add(mb, 8'd225);
            @(negedge clk);
        end
        b_iv = 0;
        qb.push_back(mb);
        chk("ovf_valid", b_ov, 1);
        chk("ovf_acc_const", b_acc, EXP_B_ACC);
        chk("ovf_flag_const", b_ovf, EXP_B_OVF);
        e = qb.pop_front();
        chk("ovf_acc_model", b_acc, e[W-1:0]);
        chk("ovf_flag_model", b_ovf, e[W]);
        b_or = 1;
        @(negedge clk);
        b_or = 0;
        chk("ovf_cleared_acc", b_acc, 0);
        chk("ovf_cleared_flag", b_ovf, 0);

        // COUNT=1 with gapped input, OUT_READY held high
        n_res = 0;
        for (int cyc = 0; cyc < 42; cyc++) begin
            if (c_ov) begin
                n_res++;
                chk("gap_q_nonempty", qc.size() > 0, 1);
                if (qc.size() > 0) begin
                    e = qc.pop_front();
                    chk("gap_acc", c_acc, e[W-1:0]);
                end
            end
            if (cyc < 40) chk("gap_ready_pattern", c_ir, (cyc % 2) == 0);
            c_iv = (cyc < 40) && ((cyc % 2) == 0);
            c_p = 8'd49;
            if (c_iv && c_ir) qc.push_back({1'b0, W'(49)});
            @(negedge clk);
        end
        c_iv = 0;
        chk("gap_results", n_res, 20);
        chk("gap_q_drained", qc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter COUNT, default 4, giving the number of products summed per result; legal range 1..15.
REQ-002 The block SHALL have parameter ACC_W, default 10, giving the accumulator width in bits; legal range 8..16.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port CLR  input  1  synchronous clear of the current accumulation.
REQ-006 The block SHALL have port IN_VALID  input  1  upstream product valid.
REQ-007 The block SHALL have port IN_READY  output  1  block can accept a product.
REQ-008 The block SHALL have port P  input  8  unsigned product from the 4x4 multiplier (P7 as MSB, P0 as LSB).
REQ-009 The block SHALL have port OUT_VALID  output  1  result held on ACC.
REQ-010 The block SHALL have port OUT_READY  input  1  downstream accepts the result.
REQ-011 The block SHALL have port ACC  output  ACC_W  accumulated unsigned sum.
REQ-012 The block SHALL have port OVF  output  1  sum exceeded 2^ACC_W-1 during this accumulation.

Function
REQ-013 The block SHALL implement two states: ACCUM (IN_READY=1, OUT_VALID=0) and HOLD (IN_READY=0, OUT_VALID=1).
REQ-014 In ACCUM, an input handshake (IN_VALID&IN_READY) SHALL add zero-extended P to ACC and increment an internal sample counter (4 bits).
REQ-015 On the handshake that brings the counter to COUNT, the block SHALL enter HOLD the next cycle, with ACC including that product (one-cycle latency from the last handshake to OUT_VALID).
REQ-016 In HOLD, ACC and OVF SHALL remain stable; P and IN_VALID SHALL be ignored.
REQ-017 An output handshake (OUT_VALID&OUT_READY) SHALL clear ACC, OVF and the counter, and return to ACCUM on the next cycle; a new product is accepted no earlier than the cycle after the output handshake.
REQ-018 OUT_VALID SHALL NOT drop without an output handshake, CLR or reset.
REQ-019 CLR=1 SHALL take priority over both handshakes: next cycle ACC=0, OVF=0, counter=0, state ACCUM; a product presented with CLR is discarded.
REQ-020 The overflow condition SHALL be: the ACC_W+1-bit sum of ACC and P exceeds 2^ACC_W-1.
REQ-021 With COUNT=1, every accepted product SHALL produce a result in HOLD on the following cycle.
REQ-022 IN_READY and OUT_VALID SHALL be registered state decodes, combinationally independent of IN_VALID and OUT_READY.

Reset
REQ-023 RST_N=0 SHALL asynchronously force state ACCUM, ACC=0, OVF=0, counter=0, OUT_VALID=0, IN_READY=1.
REQ-024 Reset asserted mid-accumulation or in HOLD SHALL discard the partial or held result; deassertion SHALL be sampled synchronously to CLK.

Configuration
REQ-025 Macro PRODUCT_ACC_SAT_EN defined: on overflow ACC SHALL saturate to 2^ACC_W-1 and OVF SHALL be set and remain set (sticky) until the output handshake, CLR or reset.
REQ-026 Macro PRODUCT_ACC_SAT_EN undefined: ACC SHALL wrap modulo 2^ACC_W and OVF SHALL be tied to 0.

Verification
REQ-027 Reset: RST_N low mid-accumulation with ACC=0x1A5 -> ACC=0, OUT_VALID=0, IN_READY=1 immediately, before any CLK edge.
REQ-028 Basic: COUNT=4, ACC_W=10, products 15*15, 3*7, 0, 9*2 (225,21,0,18) -> OUT_VALID one cycle after the 4th handshake, ACC=264, OVF=0.
REQ-029 Backpressure: hold OUT_READY=0 for 5 cycles while IN_VALID=1 with P=0xFF -> ACC stable at 264, IN_READY=0, no product consumed; OUT_READY=1 -> next cycle ACC=0, IN_READY=1.
REQ-030 Overflow: COUNT=8, ACC_W=10, eight products of 225 (sum 1800) -> with PRODUCT_ACC_SAT_EN ACC=1023, OVF=1; without it ACC=776, OVF=0.
REQ-031 Clear: after 2 of 4 products, assert CLR together with IN_VALID and P=100 -> ACC=0, counter=0, product discarded; 4 subsequent products of 1 -> ACC=4.
REQ-032 Gapped input: COUNT=1, IN_VALID toggling every cycle with P=49 -> each result ACC=49, OUT_READY=1 constantly, no product lost or duplicated over 20 results.
